// File: rtl/uart_pkg.sv
// Shared types and constants for the UART byte-stream deframer family.
package uart_pkg;

    // Deframer state encoding.
    typedef enum logic [1:0] {
        s_HUNT    = 2'd0,
        s_LEN     = 2'd1,
        s_PAYLOAD = 2'd2,
        s_CHK     = 2'd3
    } frame_state_t;

    // One-cycle frame outcome pulses; at most one bit is set at a time.
    typedef struct packed {
        logic frame_valid;
        logic chk_err;
        logic len_err;
        logic timeout_err;
    } frame_evt_t;

    localparam logic [7:0]  SYNC_BYTE_DEF      = 8'hA5;
    localparam int unsigned CLK_FREQ           = 125_000_000;
    localparam int unsigned BAUD_RATE          = 115_200;
    localparam int unsigned NBYTES_DEF         = 12;
    // Roughly four byte times at CLK_FREQ / BAUD_RATE.
    localparam int unsigned TIMEOUT_CYCLES_DEF = 43_400;

    // MSB position of payload slot i in an nbytes-wide word; slot 0 sits at the top.
    function automatic int unsigned slot_msb(input int unsigned nbytes, input int unsigned i);
        return (nbytes - i) * 8 - 1;
    endfunction

endpackage

// File: rtl/uart_frame_timeout.sv
// Inter-byte watchdog: counts idle cycles while enabled, clears on activity,
// flags expiry on the cycle the count would reach LIMIT-1.
module uart_frame_timeout
    import uart_pkg::*;
#(
    parameter int unsigned LIMIT = TIMEOUT_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic expire_c
);

    localparam int unsigned CW = (LIMIT > 2) ? $clog2(LIMIT) : 1;

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    // Expiry and next count; activity or expiry restarts the count from zero.
    always_comb begin
        expire_c = 1'b0;
        count_d  = count_q + CW'(1);
        if (en && !clr && (count_q == CW'(LIMIT - 2))) begin
            expire_c = 1'b1;
        end
        if (!en || clr || expire_c) begin
            count_d = '0;
        end
    end

    // Counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/uart_frame_rx.sv
// Byte-stream deframer: hunts for SYNC, captures a length-prefixed payload,
// verifies an XOR checksum and publishes the payload as one parallel word.
module uart_frame_rx
    import uart_pkg::*;
#(
    parameter int unsigned NBYTES         = NBYTES_DEF,
    parameter logic [7:0]  SYNC_BYTE      = SYNC_BYTE_DEF,
    parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input  logic                          iClk,
    input  logic                          iRst,
    input  logic [7:0]                    iRxByte,
    input  logic                          iRxDone,
    output logic [NBYTES*8-1:0]           oPayload,
    output logic [$clog2(NBYTES+1)-1:0]   oLen,
    output logic                          oFrameValid,
    output logic                          oChkErr,
    output logic                          oLenErr,
    output logic                          oTimeoutErr
);

    localparam int unsigned LW = $clog2(NBYTES + 1);
    localparam int unsigned PW = NBYTES * 8;

    frame_state_t state_q, state_d;
    logic [PW-1:0] buf_q, buf_d;
    logic [LW-1:0] cnt_q, cnt_d;
    logic [LW-1:0] len_q, len_d;
    logic [7:0]    chk_q, chk_d;
    logic [PW-1:0] payload_q, payload_d;
    logic [LW-1:0] olen_q, olen_d;
    frame_evt_t    evt_q, evt_d;

    logic tmo_en_c;
    logic tmo_expire_c;

    assign tmo_en_c = (state_q != s_HUNT);

    uart_frame_timeout #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk      (iClk),
        .rst      (iRst),
        .en       (tmo_en_c),
        .clr      (iRxDone),
        .expire_c (tmo_expire_c)
    );

    // Next-state, working-buffer and output-pulse logic.
    always_comb begin
        state_d   = state_q;
        buf_d     = buf_q;
        cnt_d     = cnt_q;
        len_d     = len_q;
        chk_d     = chk_q;
        payload_d = payload_q;
        olen_d    = olen_q;
        evt_d     = '0;

        unique case (state_q)
            s_HUNT: begin
                if (iRxDone && (iRxByte == SYNC_BYTE)) begin
                    state_d = s_LEN;
                    buf_d   = '0;
                    chk_d   = '0;
                    cnt_d   = '0;
                end
            end

            s_LEN: begin
                if (iRxDone) begin
                    // Range check on the full byte so large values cannot alias into range.
                    if ((iRxByte == 8'd0) || (iRxByte > 8'(NBYTES))) begin
                        evt_d.len_err = 1'b1;
                        state_d       = s_HUNT;
                    end else begin
                        len_d   = LW'(iRxByte);
                        chk_d   = iRxByte;
                        state_d = s_PAYLOAD;
                    end
                end
            end

            s_PAYLOAD: begin
                if (iRxDone) begin
                    for (int unsigned i = 0; i < NBYTES; i++) begin
                        if (cnt_q == LW'(i)) begin
                            buf_d[slot_msb(NBYTES, i) -: 8] = iRxByte;
                        end
                    end
                    chk_d = chk_q ^ iRxByte;
                    cnt_d = cnt_q + LW'(1);
                    if (cnt_q == (len_q - LW'(1))) begin
                        state_d = s_CHK;
                    end
                end
            end

            s_CHK: begin
                if (iRxDone) begin
                    if (iRxByte == chk_q) begin
                        payload_d         = buf_q;
                        olen_d            = len_q;
                        evt_d.frame_valid = 1'b1;
                    end else begin
                        evt_d.chk_err = 1'b1;
                    end
                    state_d = s_HUNT;
                end
            end

            default: begin
                state_d = s_HUNT;
            end
        endcase

        // Expiry only fires on strobe-free cycles, so it never collides with a byte.
        if (tmo_expire_c) begin
            evt_d             = '0;
            evt_d.timeout_err = 1'b1;
            state_d           = s_HUNT;
        end
    end

    // State, working registers and registered outputs.
    always_ff @(posedge iClk) begin
        if (iRst) begin
            state_q   <= s_HUNT;
            buf_q     <= '0;
            cnt_q     <= '0;
            len_q     <= '0;
            chk_q     <= '0;
            payload_q <= '0;
            olen_q    <= '0;
            evt_q     <= '0;
        end else begin
            state_q   <= state_d;
            buf_q     <= buf_d;
            cnt_q     <= cnt_d;
            len_q     <= len_d;
            chk_q     <= chk_d;
            payload_q <= payload_d;
            olen_q    <= olen_d;
            evt_q     <= evt_d;
        end
    end

    assign oPayload    = payload_q;
    assign oLen        = olen_q;
    assign oFrameValid = evt_q.frame_valid;
    assign oChkErr     = evt_q.chk_err;
    assign oLenErr     = evt_q.len_err;
    assign oTimeoutErr = evt_q.timeout_err;

endmodule

// File: tb/tb_uart_frame_rx.sv
// Bench for uart_frame_rx: frame table plus hand-timed timeout and reset sequences,
// with a scoreboard matching every outcome pulse against an expected record.
module tb_uart_frame_rx;

    localparam int unsigned NB = 12;
    localparam int unsigned TO = 100;

    localparam logic [2:0] K_VALID = 3'd1;
    localparam logic [2:0] K_CHK   = 3'd2;
    localparam logic [2:0] K_LEN   = 3'd3;
    localparam logic [2:0] K_TMO   = 3'd4;

    logic          iClk;
    logic          iRst;
    logic [7:0]    iRxByte;
    logic          iRxDone;
    logic [95:0]   oPayload;
    logic [3:0]    oLen;
    logic          oFrameValid;
    logic          oChkErr;
    logic          oLenErr;
    logic          oTimeoutErr;

    uart_frame_rx #(
        .NBYTES         (NB),
        .SYNC_BYTE      (8'hA5),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .iClk        (iClk),
        .iRst        (iRst),
        .iRxByte     (iRxByte),
        .iRxDone     (iRxDone),
        .oPayload    (oPayload),
        .oLen        (oLen),
        .oFrameValid (oFrameValid),
        .oChkErr     (oChkErr),
        .oLenErr     (oLenErr),
        .oTimeoutErr (oTimeoutErr)
    );

    // Wire bytes are right-aligned in 'bytes': byte 0 is the most significant of the n used.
    typedef struct packed {
        logic [7:0]   n;
        logic [127:0] bytes;
        logic [2:0]   kind;
        logic [95:0]  pay;
        logic [3:0]   len;
    } vec_t;

    typedef struct packed {
        logic [2:0]  kind;
        logic [95:0] pay;
        logic [3:0]  len;
        int unsigned cyc;
    } exp_t;

    exp_t        sb[$];
    vec_t        vecs[9];
    int unsigned cyc = 0;
    int unsigned drv_cyc = 0;
    int          n_checks = 0;
    int          n_fail = 0;

    initial iClk = 1'b0;
    always #5 iClk = ~iClk;

    always @(posedge iClk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic vec_t mk(input int n, input logic [127:0] b, input logic [2:0] k,
                                input logic [95:0] p, input logic [3:0] l);
        vec_t v;
        v.n     = 8'(n);
        v.bytes = b;
        v.kind  = k;
        v.pay   = p;
        v.len   = l;
        return v;
    endfunction

    function automatic logic [2:0] kind_of(input logic [3:0] p);
        if (p[3]) return K_VALID;
        if (p[2]) return K_CHK;
        if (p[1]) return K_LEN;
        if (p[0]) return K_TMO;
        return 3'd0;
    endfunction

    // Called at posedge+1; leaves the strobe high for exactly one sampling edge.
    task automatic send_byte(input logic [7:0] b);
        iRxByte = b;
        iRxDone = 1'b1;
        drv_cyc = cyc;
        @(posedge iClk);
        #1;
        iRxDone = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge iClk);
            #1;
        end
    endtask

    task automatic push(input logic [2:0] k, input logic [95:0] p, input logic [3:0] l,
                        input int unsigned at);
        exp_t e;
        e.kind = k;
        e.pay  = p;
        e.len  = l;
        e.cyc  = at;
        sb.push_back(e);
    endtask

    task automatic drain();
        for (int i = 0; i < 300; i++) begin
            if (sb.size() == 0) break;
            @(posedge iClk);
            #1;
        end
        check("drain_pending", 128'(sb.size()), 128'd0);
        sb.delete();
    endtask

    // Scoreboard monitor: every pulse must match the next expected outcome and cycle.
    logic [3:0] mon_p;
    exp_t       mon_e;
    always @(negedge iClk) begin
        if (!iRst) begin
            mon_p = {oFrameValid, oChkErr, oLenErr, oTimeoutErr};
            if (mon_p != 4'd0) begin
                check("pulse_onehot", 128'($countones(mon_p) > 1), 128'd0);
                if (sb.size() == 0) begin
                    check("unexpected_pulse", 128'(mon_p), 128'd0);
                end else begin
                    mon_e = sb.pop_front();
                    check("pulse_kind", 128'(kind_of(mon_p)), 128'(mon_e.kind));
                    check("payload", 128'(oPayload), 128'(mon_e.pay));
                    check("len", 128'(oLen), 128'(mon_e.len));
                    check("pulse_cycle", 128'(cyc), 128'(mon_e.cyc));
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        vec_t         v;
        logic [127:0] bb;
        int unsigned  n0;

        vecs[0] = mk(6,  128'hA5_03_11_22_33_03, K_VALID, {24'h112233, 72'h0}, 4'd3);
        vecs[1] = mk(5,  128'hA5_02_AA_55_00,    K_CHK,   {24'h112233, 72'h0}, 4'd3);
        vecs[2] = mk(5,  128'hA5_02_DE_AD_71,    K_VALID, {16'hDEAD, 80'h0},   4'd2);
        vecs[3] = mk(2,  128'hA5_00,             K_LEN,   {16'hDEAD, 80'h0},   4'd2);
        vecs[4] = mk(2,  128'hA5_0D,             K_LEN,   {16'hDEAD, 80'h0},   4'd2);
        vecs[5] = mk(15, 128'hA5_0C_0102030405060708090A0B0C_00, K_VALID,
                     96'h0102030405060708090A0B0C, 4'd12);
        vecs[6] = mk(8,  128'h00_FF_5A_A5_02_A5_A5_02, K_VALID, {16'hA5A5, 80'h0}, 4'd2);
        vecs[7] = mk(4,  128'hA5_01_FF_FE,       K_VALID, {8'hFF, 88'h0},     4'd1);
        vecs[8] = mk(5,  128'hA5_02_A5_A5_FF,    K_CHK,   {8'hFF, 88'h0},     4'd1);

        iRst    = 1'b1;
        iRxDone = 1'b0;
        iRxByte = 8'h00;
        idle(3);
        check("reset_payload", 128'(oPayload), 128'd0);
        check("reset_len", 128'(oLen), 128'd0);
        check("reset_pulses", 128'({oFrameValid, oChkErr, oLenErr, oTimeoutErr}), 128'd0);
        iRst = 1'b0;
        idle(2);

        // Frame table; odd entries leave a one-cycle gap, even entries run back to back.
        for (int i = 0; i < 9; i++) begin
            v  = vecs[i];
            bb = v.bytes;
            for (int k = 0; k < int'(v.n); k++) begin
                send_byte(bb[(int'(v.n) - 1 - k) * 8 +: 8]);
            end
            push(v.kind, v.pay, v.len, drv_cyc + 1);
            if ((i % 2) == 1) idle(1);
        end
        drain();

        // Silence after a partial frame: timeout pulse 99 cycles after the last strobe.
        send_byte(8'hA5);
        send_byte(8'h02);
        send_byte(8'h11);
        push(K_TMO, {8'hFF, 88'h0}, 4'd1, drv_cyc + TO);
        drain();

        // Strobe landing on the expiry cycle wins and the frame completes.
        send_byte(8'hA5);
        send_byte(8'h02);
        send_byte(8'h11);
        n0 = drv_cyc;
        while (cyc != n0 + TO - 1) begin
            @(posedge iClk);
            #1;
        end
        send_byte(8'h22);
        send_byte(8'h31);
        push(K_VALID, {16'h1122, 80'h0}, 4'd2, drv_cyc + 1);
        drain();

        // Reset mid-frame discards everything silently.
        send_byte(8'hA5);
        send_byte(8'h02);
        send_byte(8'h11);
        iRst = 1'b1;
        idle(1);
        check("midrst_payload", 128'(oPayload), 128'd0);
        check("midrst_len", 128'(oLen), 128'd0);
        check("midrst_pulses", 128'({oFrameValid, oChkErr, oLenErr, oTimeoutErr}), 128'd0);
        idle(1);
        iRst = 1'b0;
        idle(TO + 20);
        check("midrst_no_pulse", 128'(sb.size()), 128'd0);

        send_byte(8'hA5);
        send_byte(8'h01);
        send_byte(8'h7E);
        send_byte(8'h7F);
        push(K_VALID, {8'h7E, 88'h0}, 4'd1, drv_cyc + 1);
        drain();
        idle(5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
